alu_share_arbiter: RTL and testbench

//  Shares one ALU instance between NUM_REQ requesters (e.g. EX-stage address-gen and a multicycle unit).

---
 rtl/alu_share_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ALU between NUM_REQ requesters with registered operands/results.
// Optional grant locking is enabled by defining ALU_ARB_LOCK_EN.
module alu_share_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned TAG_W   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    input  logic [NUM_REQ*3-1:0]       req_ctrl,
    input  logic [NUM_REQ*TAG_W-1:0]   req_tag,
    input  logic [NUM_REQ-1:0]         req_lock,
    output logic [WIDTH-1:0]           alu_a,
    output logic [WIDTH-1:0]           alu_b,
    output logic [2:0]                 alu_ctrl,
    input  logic [WIDTH-1:0]           alu_result,
    input  logic [3:0]                 alu_flags,
    output logic [NUM_REQ-1:0]         rsp_valid,
    input  logic [NUM_REQ-1:0]         rsp_ready,
    output logic [WIDTH-1:0]           rsp_result,
    output logic [3:0]                 rsp_flags,
    output logic [TAG_W-1:0]           rsp_tag,
    output logic                       busy
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [WIDTH-1:0] a_q, b_q, result_q;
    logic [2:0]       ctrl_q;
    logic [TAG_W-1:0] tag_q;
    logic [3:0]       flags_q;
    logic             accept;
    logic             hold_ptr;
    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic [WIDTH-1:0] sel_a, sel_b;
    logic [2:0]       sel_ctrl;
    logic [TAG_W-1:0] sel_tag;

    // First valid requester at or after rr_ptr, wrapping.
    always_comb begin : rr_pick
        int unsigned idx;
        idx        = 0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (32'(rr_ptr_q) + k) % NUM_REQ;
            if (!pick_found && req_valid[idx]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(idx);
            end
        end
    end

`ifdef ALU_ARB_LOCK_EN
    logic lock_q, lock_d;
    assign hold_ptr = lock_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lock_q <= 1'b0;
        end else begin
            lock_q <= lock_d;
        end
    end
`else
    logic unused_lock;
    assign unused_lock = ^req_lock;
    assign hold_ptr    = 1'b0;
`endif

    always_comb begin : fsm
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        grant_d   = grant_q;
        accept    = 1'b0;
        req_ready = '0;
        rsp_valid = '0;
`ifdef ALU_ARB_LOCK_EN
        lock_d    = lock_q;
`endif
        unique case (state_q)
            StIdle: begin
`ifdef ALU_ARB_LOCK_EN
                if (lock_q) begin
                    // Only the lock owner may be granted; an idle owner gives the lock up.
                    if (req_valid[grant_q]) begin
                        accept = 1'b1;
                    end else begin
                        lock_d = 1'b0;
                    end
                end else if (pick_found) begin
                    accept  = 1'b1;
                    grant_d = pick_idx;
                end
                if (accept) begin
                    lock_d = req_lock[grant_d];
                end
`else
                if (pick_found) begin
                    accept  = 1'b1;
                    grant_d = pick_idx;
                end
`endif
                if (accept) begin
                    req_ready[grant_d] = 1'b1;
                    state_d            = StExec;
                end
            end
            StExec: state_d = StResp;
            StResp: begin
                rsp_valid[grant_q] = 1'b1;
                if (rsp_ready[grant_q]) begin
                    state_d = StIdle;
                    if (!hold_ptr) begin
                        rr_ptr_d = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin : req_mux
        sel_a    = '0;
        sel_b    = '0;
        sel_ctrl = '0;
        sel_tag  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (IDX_W'(i) == grant_d) begin
                sel_a    = req_a[i*WIDTH +: WIDTH];
                sel_b    = req_b[i*WIDTH +: WIDTH];
                sel_ctrl = req_ctrl[i*3 +: 3];
                sel_tag  = req_tag[i*TAG_W +: TAG_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            ctrl_q   <= '0;
            tag_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            if (accept) begin
                a_q    <= sel_a;
                b_q    <= sel_b;
                ctrl_q <= sel_ctrl;
                tag_q  <= sel_tag;
            end
            if (state_q == StExec) begin
                result_q <= alu_result;
                flags_q  <= alu_flags;
            end
        end
    end

    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_ctrl   = ctrl_q;
    assign rsp_result = result_q;
    assign rsp_flags  = flags_q;
    assign rsp_tag    = tag_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Testbench for alu_share_arbiter: behavioural ALU, scoreboard queue, vector table, corner sequences.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid, req_ready, req_lock, rsp_valid, rsp_ready;
    logic [63:0] req_a, req_b;
    logic [5:0]  req_ctrl;
    logic [7:0]  req_tag;
    logic [31:0] alu_a, alu_b, alu_result, rsp_result;
    logic [2:0]  alu_ctrl;
    logic [3:0]  alu_flags, rsp_flags, rsp_tag;
    logic        busy;

    alu_share_arbiter #(.NUM_REQ(2), .WIDTH(32), .TAG_W(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_ctrl(req_ctrl), .req_tag(req_tag),
        .req_lock(req_lock),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_tag(rsp_tag),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Returns {C,V,Z,N,result}; subtract is A + ~B + 1 with carry-out.
    function automatic logic [35:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] c);
        logic [32:0] s;
        logic [31:0] r;
        logic        cy, v;
        s = '0; r = '0; cy = 1'b0; v = 1'b0;
        case (c)
            3'b000: begin
                s = {1'b0, a} + {1'b0, b}; r = s[31:0]; cy = s[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            3'b001: begin
                s = {1'b0, a} + {1'b0, ~b} + 33'd1; r = s[31:0]; cy = s[32];
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            3'b010: r = a & b;
            3'b011: r = a | b;
            3'b101: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: r = '0;
        endcase
        return {cy, v, (r == 32'd0), r[31], r};
    endfunction

    always_comb {alu_flags, alu_result} = alu_ref(alu_a, alu_b, alu_ctrl);

    typedef struct {
        int          id;
        logic [31:0] res;
        logic [3:0]  flg;
        logic [3:0]  tag;
        int          cyc;
    } exp_t;

    typedef struct {
        int          id;
        logic [31:0] a, b;
        logic [2:0]  ctrl;
        logic [3:0]  tag;
        logic [31:0] res;
        logic [3:0]  flg;
    } vec_t;

    exp_t        sb[$];
    int          grant_log[$];
    int          errors = 0, checks = 0;
    int          cyc = 0, acc_cnt = 0, rsp_cnt = 0, last_acc = 0;
    bit          rsp_seen = 1'b0, have_acc = 1'b0;
    logic [31:0] last_res;
    logic [3:0]  last_flg, last_tag;
    vec_t        tbl[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Negedge monitor: pushes expectations on accept, pops and compares on response handshake.
    task automatic sample();
        exp_t e;
        logic [1:0] ev;
        if (!rst) begin
            sb.delete(); rsp_seen = 1'b0; have_acc = 1'b0;
            return;
        end
        chk("req_ready_legal", {63'd0, ((req_ready & ~req_valid) != 2'b00) ||
            (busy && req_ready != 2'b00) || !$onehot0(req_ready)}, 64'd0);
        for (int i = 0; i < 2; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                e.id = i;
                {e.flg, e.res} = alu_ref(req_a[i*32 +: 32], req_b[i*32 +: 32], req_ctrl[i*3 +: 3]);
                e.tag = req_tag[i*4 +: 4];
                e.cyc = cyc;
                if (have_acc) chk("issue_interval", {63'd0, (cyc - last_acc) < 3}, 64'd0);
                have_acc = 1'b1; last_acc = cyc;
                sb.push_back(e); grant_log.push_back(i); acc_cnt++;
            end
        end
        if (rsp_valid != 2'b00) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
            end else begin
                ev = 2'b01 << sb[0].id;
                if (!rsp_seen) begin
                    chk("rsp_latency", 64'(cyc - sb[0].cyc), 64'd2);
                    rsp_seen = 1'b1;
                end
                chk("rsp_valid_onehot", 64'(rsp_valid), 64'(ev));
                if (rsp_ready[sb[0].id]) begin
                    chk("rsp_result", 64'(rsp_result), 64'(sb[0].res));
                    chk("rsp_flags", 64'(rsp_flags), 64'(sb[0].flg));
                    chk("rsp_tag", 64'(rsp_tag), 64'(sb[0].tag));
                    last_res = rsp_result; last_flg = rsp_flags; last_tag = rsp_tag;
                    void'(sb.pop_front());
                    rsp_seen = 1'b0;
                    rsp_cnt++;
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] c, input logic [3:0] t, input logic lk);
        req_a[id*32 +: 32] = a;
        req_b[id*32 +: 32] = b;
        req_ctrl[id*3 +: 3] = c;
        req_tag[id*4 +: 4]  = t;
        req_lock[id]        = lk;
    endtask

    task automatic wait_acc(input int target);
        int n = 0;
        while (acc_cnt < target && n < 40) begin tick(); n++; end
        if (acc_cnt < target) chk("accept_timeout", 64'(acc_cnt), 64'(target));
    endtask

    task automatic wait_rsp(input int target);
        int n = 0;
        while (rsp_cnt < target && n < 40) begin tick(); n++; end
        if (rsp_cnt < target) chk("rsp_timeout", 64'(rsp_cnt), 64'(target));
    endtask

    task automatic check_all_zero(input string pfx);
        chk({pfx, "_req_ready"}, 64'(req_ready), 64'd0);
        chk({pfx, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({pfx, "_busy"}, 64'(busy), 64'd0);
        chk({pfx, "_alu_a_b_ctrl"}, {alu_a, alu_b[28:0], alu_ctrl}, 64'd0);
        chk({pfx, "_rsp_result"}, 64'(rsp_result), 64'd0);
        chk({pfx, "_rsp_flags_tag"}, 64'({rsp_flags, rsp_tag}), 64'd0);
    endtask

    initial begin
        int base;
        int exp_order[3];
        tbl[0] = '{0, 32'd5,        32'd3,        3'b000, 4'd1, 32'd8,        4'b0000};
        tbl[1] = '{1, 32'd3,        32'd3,        3'b001, 4'd2, 32'd0,        4'b1010};
        tbl[2] = '{0, 32'h80000000, 32'd1,        3'b001, 4'd3, 32'h7FFFFFFF, 4'b1100};
        tbl[3] = '{1, 32'hF0F01234, 32'h0FF0FFFF, 3'b010, 4'd4, 32'h00F01234, 4'b0000};
        tbl[4] = '{0, 32'h80000000, 32'd1,        3'b011, 4'd5, 32'h80000001, 4'b0001};
        tbl[5] = '{1, 32'h12345678, 32'd9,        3'b100, 4'd6, 32'd0,        4'b0010};
        tbl[6] = '{0, 32'h7FFFFFFF, 32'd1,        3'b000, 4'd7, 32'h80000000, 4'b0101};
        tbl[7] = '{1, 32'hFFFFFFFF, 32'd1,        3'b000, 4'd8, 32'd0,        4'b1010};
        tbl[8] = '{0, 32'hFFFFFFFF, 32'd2,        3'b101, 4'd9, 32'd1,        4'b0000};

        rst = 1'b0; req_valid = '0; req_lock = '0; rsp_ready = 2'b11;
        req_a = '0; req_b = '0; req_ctrl = '0; req_tag = '0;
        #2;
        check_all_zero("reset");
        tick(); tick();
        rst = 1'b1;
        tick();

        // Vector table, one op at a time, alternating requesters.
        for (int k = 0; k < 9; k++) begin
            set_req(tbl[k].id, tbl[k].a, tbl[k].b, tbl[k].ctrl, tbl[k].tag, 1'b0);
            req_valid[tbl[k].id] = 1'b1;
            wait_acc(acc_cnt + 1);
            req_valid = '0;
            wait_rsp(rsp_cnt + 1);
            chk($sformatf("tbl%0d_result", k), 64'(last_res), 64'(tbl[k].res));
            chk($sformatf("tbl%0d_flags", k), 64'(last_flg), 64'(tbl[k].flg));
            chk($sformatf("tbl%0d_tag", k), 64'(last_tag), 64'(tbl[k].tag));
        end

        // Backpressure: response held, a competing request must not be accepted.
        rsp_ready = 2'b00;
        set_req(1, 32'd10, 32'd20, 3'b000, 4'hA, 1'b0);
        req_valid[1] = 1'b1;
        base = acc_cnt;
        wait_acc(base + 1);
        req_valid = 2'b01;
        set_req(0, 32'd1, 32'd1, 3'b000, 4'h3, 1'b0);
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("bp_rsp_valid", 64'(rsp_valid), 64'd2);
            chk("bp_rsp_result", 64'(rsp_result), 64'd30);
            chk("bp_req_ready", 64'(req_ready), 64'd0);
            chk("bp_busy", 64'(busy), 64'd1);
            tick();
        end
        req_valid = '0;
        rsp_ready = 2'b11;
        wait_rsp(rsp_cnt + 1);
        chk("bp_final_result", 64'(last_res), 64'd30);
        for (int k = 0; k < 4; k++) tick();
        chk("dropped_valid_no_accept", 64'(acc_cnt), 64'(base + 1));

        // Advance rr_ptr to 1, then reset during a req1 EXEC.
        set_req(0, 32'd2, 32'd2, 3'b000, 4'h1, 1'b0);
        req_valid = 2'b01;
        wait_acc(acc_cnt + 1);
        req_valid = '0;
        wait_rsp(rsp_cnt + 1);
        set_req(1, 32'h55, 32'h66, 3'b011, 4'hF, 1'b0);
        req_valid = 2'b10;
        wait_acc(acc_cnt + 1);
        req_valid = '0;
        chk("pre_reset_busy", 64'(busy), 64'd1);
        #1 rst = 1'b0;
        #1 check_all_zero("midexec");
        tick(); tick();
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("post_reset_no_rsp", 64'(rsp_valid), 64'd0);
            tick();
        end

        // Contention from reset: both valid every cycle, grants must alternate starting at 0.
        set_req(0, 32'd100, 32'd1, 3'b001, 4'h5, 1'b0);
        set_req(1, 32'd7,   32'd8, 3'b000, 4'hC, 1'b0);
        base = grant_log.size();
        req_valid = 2'b11;
        wait_acc(acc_cnt + 4);
        req_valid = '0;
        wait_rsp(rsp_cnt + 1);
        for (int k = 0; k < 4; k++) begin
            if (grant_log.size() > base + k)
                chk($sformatf("contention_grant%0d", k), 64'(grant_log[base + k]), 64'(k % 2));
        end
        chk("contention_sb_empty", 64'(sb.size()), 64'd0);

        // Lock: req1 locks its grant while req0 is waiting.
`ifdef ALU_ARB_LOCK_EN
        exp_order = '{1, 1, 0};
`else
        exp_order = '{1, 0, 1};
`endif
        tick();
        base = grant_log.size();
        set_req(1, 32'd40, 32'd2, 3'b000, 4'h6, 1'b1);
        set_req(0, 32'd9,  32'd4, 3'b001, 4'h2, 1'b0);
        req_valid = 2'b10;
        wait_acc(acc_cnt + 1);
        req_lock[1] = 1'b0;
        req_valid = 2'b11;
        wait_acc(acc_cnt + 2);
        req_valid = '0;
        wait_rsp(rsp_cnt + 1);
        for (int k = 0; k < 3; k++) begin
            if (grant_log.size() > base + k)
                chk($sformatf("lock_grant%0d", k), 64'(grant_log[base + k]), 64'(exp_order[k]));
        end
        for (int k = 0; k < 3; k++) tick();
        chk("final_sb_empty", 64'(sb.size()), 64'd0);
        chk("final_idle", 64'(busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, want finished");
        $fatal(1, "timeout");
    end

endmodule
